// File: rtl/msrh_div_share_ctrl_pkg.sv
// Shared types for the shared divider: op encoding, controller states, data width.
package msrh_pkg;
  localparam int XLEN = 64;

  typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} div_state_t;
endpackage

// File: rtl/msrh_div_share_ctrl_if.sv
// Request/response bundle between the ALU pipes and the shared divider.
interface msrh_div_share_ctrl_if #(
  parameter int REQ_NUM = 2,
  parameter int XLEN    = msrh_pkg::XLEN,
  parameter int TAG_W   = 4
);
  logic [REQ_NUM-1:0]            i_req_valid;
  logic [REQ_NUM-1:0]            o_req_ready;
  logic [REQ_NUM-1:0][1:0]       i_req_op;
  logic [REQ_NUM-1:0][XLEN-1:0]  i_req_rs1;
  logic [REQ_NUM-1:0][XLEN-1:0]  i_req_rs2;
  logic [REQ_NUM-1:0][TAG_W-1:0] i_req_tag;
  logic                          i_flush;
  logic                          o_resp_valid;
  logic                          i_resp_ready;
  logic [REQ_NUM-1:0]            o_resp_port;
  logic [TAG_W-1:0]              o_resp_tag;
  logic [XLEN-1:0]               o_resp_data;
  logic                          o_busy;

  modport master (
    output i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_tag, i_flush, i_resp_ready,
    input  o_req_ready, o_resp_valid, o_resp_port, o_resp_tag, o_resp_data, o_busy
  );
  modport slave (
    input  i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_tag, i_flush, i_resp_ready,
    output o_req_ready, o_resp_valid, o_resp_port, o_resp_tag, o_resp_data, o_busy
  );
endinterface

// File: rtl/msrh_div_core.sv
// Unsigned restoring divider, one quotient bit per step; no sign handling.
module msrh_div_core #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt
);
  logic [XLEN-1:0] quo, dsr;
  logic [XLEN:0]   rem, rem_step;
  logic [XLEN+1:0] diff;
  logic            take;

  // Partial remainder stays below the divisor, so the extra bits only carry the borrow.
  always_comb begin
    diff     = {rem, quo[XLEN-1]} - {2'b00, dsr};
    take     = !diff[XLEN+1];
    rem_step = take ? diff[XLEN:0] : {rem[XLEN-1:0], quo[XLEN-1]};
    quo_nxt  = {quo[XLEN-2:0], take};
    rem_nxt  = rem_step[XLEN-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= quo_nxt;
      rem <= rem_step;
    end
  end
endmodule

// File: rtl/msrh_div_share_ctrl.sv
// Round-robin shared divider controller: arbitration, special cases, sign fixup, FSM.
module msrh_div_share_ctrl #(
  parameter int REQ_NUM = 2,
  parameter int XLEN    = msrh_pkg::XLEN,
  parameter int TAG_W   = 4
) (
  input logic                  i_clk,
  input logic                  i_reset,
  msrh_div_share_ctrl_if.slave bus
);
  import msrh_pkg::*;

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = $clog2(XLEN);

  div_state_t         state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr, win;
  logic [REQ_NUM-1:0] grant, ready;
  logic               found, accept;
  logic [CNT_W-1:0]   cnt;
  logic               is_rem, neg_q, neg_r;
  logic [XLEN-1:0]    rs1, rs2, abs1, abs2, special_data;
  logic [XLEN-1:0]    quo_nxt, rem_nxt, quo_fix, rem_fix;
  logic [1:0]         sel_op;
  logic               sel_signed, sel_rem, div_zero, ovf, special;
  logic [REQ_NUM-1:0] resp_port;
  logic [TAG_W-1:0]   resp_tag;
  logic [XLEN-1:0]    resp_data;

  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % REQ_NUM;
      if (!found && bus.i_req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        win        = PTR_W'(idx);
      end
    end
  end

  assign ready  = (state == IDLE && !bus.i_flush) ? grant : '0;
  assign accept = |(bus.i_req_valid & ready);

  // Winner's operands are classified in the accept cycle so specials skip CALC.
  always_comb begin
    sel_op       = bus.i_req_op[win];
    rs1          = bus.i_req_rs1[win];
    rs2          = bus.i_req_rs2[win];
    sel_signed   = !sel_op[0];
    sel_rem      = sel_op[1];
    div_zero     = (rs2 == '0);
    ovf          = sel_signed && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    special      = div_zero || ovf;
    abs1         = (sel_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    abs2         = (sel_signed && rs2[XLEN-1]) ? -rs2 : rs2;
    special_data = div_zero ? (sel_rem ? rs1 : '1) : (sel_rem ? '0 : rs1);
    quo_fix      = neg_q ? -quo_nxt : quo_nxt;
    rem_fix      = neg_r ? -rem_nxt : rem_nxt;
  end

  msrh_div_core #(.XLEN(XLEN)) u_core (
    .clk      (i_clk),
    .reset    (i_reset),
    .start    (accept && !special),
    .step     (state == CALC),
    .dividend (abs1),
    .divisor  (abs2),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  always_comb begin
    state_nxt = state;
    if (bus.i_flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = special ? DONE : CALC;
        CALC:    if (cnt == '0) state_nxt = DONE;
        DONE:    if (bus.i_resp_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cnt       <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      resp_port <= '0;
      resp_tag  <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr    <= (win == PTR_W'(REQ_NUM-1)) ? '0 : win + 1'b1;
        is_rem    <= sel_rem;
        neg_q     <= sel_signed && (rs1[XLEN-1] ^ rs2[XLEN-1]);
        neg_r     <= sel_signed && rs1[XLEN-1];
        resp_port <= grant;
        resp_tag  <= bus.i_req_tag[win];
        cnt       <= CNT_W'(XLEN-1);
        if (special) resp_data <= special_data;
      end else if (state == CALC && !bus.i_flush) begin
        cnt <= cnt - 1'b1;
        if (cnt == '0) resp_data <= is_rem ? rem_fix : quo_fix;
      end
    end
  end

  assign bus.o_req_ready  = ready;
  assign bus.o_resp_valid = (state == DONE);
  assign bus.o_resp_port  = resp_port;
  assign bus.o_resp_tag   = resp_tag;
  assign bus.o_resp_data  = resp_data;
  assign bus.o_busy       = (state != IDLE);
endmodule

// File: tb/tb_msrh_div_share_ctrl.sv
// Directed bench for the shared divider: latency, rotation, specials, flush, backpressure.
module tb_msrh_div_share_ctrl;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG6 = 64'hFFFF_FFFF_FFFF_FFFA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  msrh_div_share_ctrl_if #(.REQ_NUM(2), .XLEN(64), .TAG_W(4)) bus ();

  msrh_div_share_ctrl #(.REQ_NUM(2), .XLEN(64), .TAG_W(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic do_reset();
    rst = 1'b1;
    bus.i_req_valid = '0; bus.i_req_op = '0; bus.i_req_rs1 = '0; bus.i_req_rs2 = '0;
    bus.i_req_tag = '0; bus.i_flush = 1'b0; bus.i_resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] tag);
    bus.i_req_op[p] = op; bus.i_req_rs1[p] = a; bus.i_req_rs2[p] = b; bus.i_req_tag[p] = tag;
    bus.i_req_valid[p] = 1'b1;
  endtask

  // Presents a request and holds it through the accepting edge (bounded wait for ready).
  task automatic issue(input int p, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
    int w;
    @(negedge clk);
    set_req(p, op, a, b, tag);
    #1 w = 0;
    while (!bus.o_req_ready[p] && w < 100) begin
      @(negedge clk); #1 w++;
    end
    @(posedge clk);
    #1 bus.i_req_valid[p] = 1'b0;
  endtask

  // Cycles from the accepting edge until o_resp_valid; -1 when the bound expires.
  task automatic wait_resp(output int lat);
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (bus.o_resp_valid) begin lat = k; break; end
    end
  endtask

  task automatic handshake();
    bus.i_resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (bus.o_resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%0b exp=0", bus.o_resp_valid); end
    tests++; if (bus.o_resp_port !== 2'b00) begin fails++; $display("FAIL reset_port got=%0b exp=00", bus.o_resp_port); end
    tests++; if (bus.o_resp_tag !== 4'h0) begin fails++; $display("FAIL reset_tag got=%0h exp=0", bus.o_resp_tag); end
    tests++; if (bus.o_resp_data !== 64'h0) begin fails++; $display("FAIL reset_data got=%0h exp=0", bus.o_resp_data); end
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%0b exp=0", bus.o_busy); end
    tests++; if (bus.o_req_ready !== 2'b00) begin fails++; $display("FAIL reset_ready got=%0b exp=00", bus.o_req_ready); end
  endtask

  task automatic test_divu_remu();
    int lat;
    issue(0, msrh_pkg::DIVU, 64'd100, 64'd7, 4'h3);
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL divu_latency got=%0d exp=65", lat); end
    tests++; if (bus.o_resp_data !== 64'd14) begin fails++; $display("FAIL divu_data got=%0h exp=e", bus.o_resp_data); end
    tests++; if (bus.o_resp_port !== 2'b01) begin fails++; $display("FAIL divu_port got=%0b exp=01", bus.o_resp_port); end
    tests++; if (bus.o_resp_tag !== 4'h3) begin fails++; $display("FAIL divu_tag got=%0h exp=3", bus.o_resp_tag); end
    handshake();
    issue(0, msrh_pkg::REMU, 64'd100, 64'd7, 4'h4);
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL remu_latency got=%0d exp=65", lat); end
    tests++; if (bus.o_resp_data !== 64'd2) begin fails++; $display("FAIL remu_data got=%0h exp=2", bus.o_resp_data); end
    tests++; if (bus.o_resp_tag !== 4'h4) begin fails++; $display("FAIL remu_tag got=%0h exp=4", bus.o_resp_tag); end
    handshake();
  endtask

  task automatic test_round_robin();
    int lat;
    do_reset();
    @(negedge clk);
    set_req(0, msrh_pkg::DIV, NEG6, 64'd4, 4'h1);
    set_req(1, msrh_pkg::DIV, NEG6, 64'd4, 4'h2);
    #1;
    tests++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL rr_grant0 got=%0b exp=01", bus.o_req_ready); end
    @(posedge clk);
    #1 bus.i_req_valid[0] = 1'b0;
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL rr_lat0 got=%0d exp=65", lat); end
    tests++; if (bus.o_resp_data !== ONES) begin fails++; $display("FAIL rr_data0 got=%0h exp=%0h", bus.o_resp_data, ONES); end
    tests++; if (bus.o_resp_port !== 2'b01) begin fails++; $display("FAIL rr_port0 got=%0b exp=01", bus.o_resp_port); end
    tests++; if (bus.o_resp_tag !== 4'h1) begin fails++; $display("FAIL rr_tag0 got=%0h exp=1", bus.o_resp_tag); end
    handshake();
    @(negedge clk); #1;
    tests++; if (bus.o_req_ready !== 2'b10) begin fails++; $display("FAIL rr_grant1 got=%0b exp=10", bus.o_req_ready); end
    @(posedge clk);
    #1 bus.i_req_valid[1] = 1'b0;
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL rr_lat1 got=%0d exp=65", lat); end
    tests++; if (bus.o_resp_data !== ONES) begin fails++; $display("FAIL rr_data1 got=%0h exp=%0h", bus.o_resp_data, ONES); end
    tests++; if (bus.o_resp_port !== 2'b10) begin fails++; $display("FAIL rr_port1 got=%0b exp=10", bus.o_resp_port); end
    tests++; if (bus.o_resp_tag !== 4'h2) begin fails++; $display("FAIL rr_tag1 got=%0h exp=2", bus.o_resp_tag); end
    handshake();
    @(negedge clk);
    set_req(0, msrh_pkg::DIV, NEG6, 64'd4, 4'h5);
    set_req(1, msrh_pkg::DIV, NEG6, 64'd4, 4'h6);
    #1;
    tests++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL rr_grant2 got=%0b exp=01", bus.o_req_ready); end
    bus.i_req_valid = '0;
  endtask

  task automatic test_div_zero();
    int lat;
    issue(0, msrh_pkg::DIV, 64'd5, 64'd0, 4'h7);
    wait_resp(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL dz_div_lat got=%0d exp=1", lat); end
    tests++; if (bus.o_resp_data !== ONES) begin fails++; $display("FAIL dz_div_data got=%0h exp=%0h", bus.o_resp_data, ONES); end
    handshake();
    issue(1, msrh_pkg::REM, 64'd5, 64'd0, 4'h8);
    wait_resp(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL dz_rem_lat got=%0d exp=1", lat); end
    tests++; if (bus.o_resp_data !== 64'd5) begin fails++; $display("FAIL dz_rem_data got=%0h exp=5", bus.o_resp_data); end
    handshake();
  endtask

  task automatic test_overflow();
    int lat;
    issue(0, msrh_pkg::DIV, MIN, ONES, 4'h9);
    wait_resp(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL ovf_div_lat got=%0d exp=1", lat); end
    tests++; if (bus.o_resp_data !== MIN) begin fails++; $display("FAIL ovf_div_data got=%0h exp=%0h", bus.o_resp_data, MIN); end
    handshake();
    issue(0, msrh_pkg::REM, MIN, ONES, 4'hA);
    wait_resp(lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL ovf_rem_lat got=%0d exp=1", lat); end
    tests++; if (bus.o_resp_data !== 64'd0) begin fails++; $display("FAIL ovf_rem_data got=%0h exp=0", bus.o_resp_data); end
    handshake();
  endtask

  task automatic test_flush();
    int lat;
    issue(0, msrh_pkg::DIVU, 64'd1000, 64'd3, 4'h5);
    repeat (10) @(negedge clk);
    tests++; if (bus.o_busy !== 1'b1) begin fails++; $display("FAIL flush_busy_before got=%0b exp=1", bus.o_busy); end
    bus.i_flush = 1'b1;
    @(posedge clk);
    #1 bus.i_flush = 1'b0;
    @(negedge clk);
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL flush_busy_after got=%0b exp=0", bus.o_busy); end
    tests++; if (bus.o_resp_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got=%0b exp=0", bus.o_resp_valid); end
    set_req(0, msrh_pkg::DIVU, 64'd1000, 64'd3, 4'h6);
    #1;
    tests++; if (bus.o_req_ready !== 2'b01) begin fails++; $display("FAIL flush_reaccept got=%0b exp=01", bus.o_req_ready); end
    @(posedge clk);
    #1 bus.i_req_valid[0] = 1'b0;
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL flush_new_lat got=%0d exp=65", lat); end
    tests++; if (bus.o_resp_data !== 64'd333) begin fails++; $display("FAIL flush_new_data got=%0h exp=14d", bus.o_resp_data); end
    tests++; if (bus.o_resp_tag !== 4'h6) begin fails++; $display("FAIL flush_new_tag got=%0h exp=6", bus.o_resp_tag); end
    handshake();
    // Flush while idle must block the grant for that cycle.
    @(negedge clk);
    set_req(1, msrh_pkg::DIVU, 64'd9, 64'd3, 4'h2);
    bus.i_flush = 1'b1;
    #1;
    tests++; if (bus.o_req_ready !== 2'b00) begin fails++; $display("FAIL flush_idle_ready got=%0b exp=00", bus.o_req_ready); end
    @(posedge clk);
    #1 bus.i_flush = 1'b0; bus.i_req_valid = '0;
    @(negedge clk);
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL flush_idle_busy got=%0b exp=0", bus.o_busy); end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(1, msrh_pkg::REMU, 64'd100, 64'd7, 4'h9);
    wait_resp(lat);
    tests++; if (lat !== 65) begin fails++; $display("FAIL bp_lat got=%0d exp=65", lat); end
    set_req(0, msrh_pkg::DIVU, 64'd8, 64'd2, 4'h1);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++; if (bus.o_resp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid c=%0d got=%0b exp=1", c, bus.o_resp_valid); end
      tests++; if (bus.o_resp_data !== 64'd2) begin fails++; $display("FAIL bp_data c=%0d got=%0h exp=2", c, bus.o_resp_data); end
      tests++; if (bus.o_resp_tag !== 4'h9) begin fails++; $display("FAIL bp_tag c=%0d got=%0h exp=9", c, bus.o_resp_tag); end
      tests++; if (bus.o_resp_port !== 2'b10) begin fails++; $display("FAIL bp_port c=%0d got=%0b exp=10", c, bus.o_resp_port); end
      tests++; if (bus.o_req_ready !== 2'b00) begin fails++; $display("FAIL bp_ready c=%0d got=%0b exp=00", c, bus.o_req_ready); end
      @(negedge clk);
    end
    handshake();
    @(negedge clk);
    tests++; if (bus.o_resp_valid !== 1'b0) begin fails++; $display("FAIL bp_valid_after got=%0b exp=0", bus.o_resp_valid); end
    tests++; if (bus.o_busy !== 1'b0) begin fails++; $display("FAIL bp_busy_after got=%0b exp=0", bus.o_busy); end
    bus.i_req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_divu_remu();
    test_round_robin();
    test_div_zero();
    test_overflow();
    test_flush();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
